// File: rtl/jpeg_pixel_sink.sv
// jpeg_pixel_sink: FWFT pixel FIFO with frame position tags; JPEG_PIXEL_SINK_RGB565_EN selects RGB565 output
module jpeg_pixel_sink #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [15:0]   img_width,
  input  logic [15:0]   img_height,
  input  logic [7:0]    r_in,
  input  logic [7:0]    g_in,
  input  logic [7:0]    b_in,
  input  logic          rgb_valid,
  output logic [23:0]   m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sof,
  output logic          m_eol,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          frame_done
);
`ifdef JPEG_PIXEL_SINK_RGB565_EN
  localparam int DW = 16;
`else
  localparam int DW = 24;
`endif
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t r_state, w_next;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic [15:0] r_w, r_h, r_inx, r_iny, r_outx, r_outy;
  logic r_ovf, r_done;
  logic w_full, w_pop, w_push, w_in_eol, w_in_last, w_out_eol, w_out_last;
  logic [DW-1:0] w_pix, w_head;
`ifdef JPEG_PIXEL_SINK_RGB565_EN
  assign w_pix = {r_in[7:3], g_in[7:2], b_in[7:3]};
  assign m_data = m_valid ? {8'h00, w_head} : 24'h0;
`else
  assign w_pix = {r_in, g_in, b_in};
  assign m_data = m_valid ? w_head : 24'h0;
`endif
  assign w_head = r_mem[r_rp[AW-1:0]];
  assign level = r_wp - r_rp;
  assign m_valid = level != '0;
  assign w_full = level == (AW+1)'(DEPTH);
  assign w_pop = m_valid && m_ready && !frame_start;
  assign w_push = r_state == ACTIVE && rgb_valid && (!w_full || w_pop) && !frame_start;
  assign w_in_eol = r_inx == r_w - 16'd1;
  assign w_in_last = w_in_eol && r_iny == r_h - 16'd1;
  assign w_out_eol = r_outx == r_w - 16'd1;
  assign w_out_last = w_out_eol && r_outy == r_h - 16'd1;
  assign m_sof = m_valid && r_outx == '0 && r_outy == '0;
  assign m_eol = m_valid && w_out_eol;
  assign overflow = r_ovf;
  assign frame_done = r_done;
  always_comb begin
    w_next = r_state;
    if (frame_start) w_next = (img_width != '0 && img_height != '0) ? ACTIVE : IDLE;
    else if (w_pop && w_out_last) w_next = IDLE;
    else if (w_push && w_in_last) w_next = DRAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_pix;
  end
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      r_wp <= '0;
      r_rp <= '0;
      r_inx <= '0;
      r_iny <= '0;
      r_outx <= '0;
      r_outy <= '0;
      r_ovf <= 1'b0;
      r_done <= 1'b0;
      r_w <= rst ? 16'h0 : img_width;
      r_h <= rst ? 16'h0 : img_height;
    end else begin
      r_done <= w_pop && w_out_last;
      if (r_state == ACTIVE && rgb_valid && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
        r_inx <= w_in_eol ? 16'h0 : r_inx + 16'd1;
        r_iny <= w_in_last ? 16'h0 : w_in_eol ? r_iny + 16'd1 : r_iny;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
        r_outx <= w_out_eol ? 16'h0 : r_outx + 16'd1;
        r_outy <= w_out_last ? 16'h0 : w_out_eol ? r_outy + 16'd1 : r_outy;
      end
    end
  end
endmodule

// File: tb/tb_jpeg_pixel_sink.sv
// tb_jpeg_pixel_sink: queue-based frame model checked every cycle plus directed literal checks
module tb_jpeg_pixel_sink;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 0, rst = 1, frame_start = 0, rgb_valid = 0, m_ready = 0;
  logic [15:0] img_width = 0, img_height = 0;
  logic [7:0] r_in = 0, g_in = 0, b_in = 0;
  logic [23:0] m_data;
  logic m_valid, m_sof, m_eol, overflow, frame_done;
  logic [AW:0] level;
  jpeg_pixel_sink #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .img_width(img_width), .img_height(img_height),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .rgb_valid(rgb_valid), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .level(level), .overflow(overflow), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  typedef struct {logic [23:0] d; int x; int y;} pix_t;
  pix_t q[$];
  int errs = 0, nchk = 0, dcount = 0;
  int ms = 0, mw = 0, mh = 0, pc = 0, oc = 0;
  bit movf = 0, mdone = 0, armed = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [23:0] cv(logic [23:0] p);
`ifdef JPEG_PIXEL_SINK_RGB565_EN
    return {8'h00, p[23:19], p[15:10], p[7:3]};
`else
    return p;
`endif
  endfunction
  function automatic logic [23:0] pix(int i);
    return {8'(i * 16 + 3), 8'(192 - i), 8'(i * 5 + 1)};
  endfunction
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
      chk("level", 32'(level), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("frame_done", 32'(frame_done), 32'(mdone));
      chk("m_data", 32'(m_data), q.size() != 0 ? 32'(q[0].d) : 32'h0);
      chk("m_sof", 32'(m_sof), 32'(q.size() != 0 && q[0].x == 0 && q[0].y == 0));
      chk("m_eol", 32'(m_eol), 32'(q.size() != 0 && q[0].x == mw - 1));
      if (frame_done) dcount++;
    end
    if (rst) begin
      q.delete();
      {ms, mw, mh, pc, oc} = '0;
      {movf, mdone} = '0;
      armed = 1;
    end else if (frame_start) begin
      q.delete();
      mw = int'(img_width);
      mh = int'(img_height);
      ms = (mw != 0 && mh != 0) ? 1 : 0;
      {pc, oc} = '0;
      {movf, mdone} = '0;
    end else begin
      automatic int tot = mw * mh;
      automatic bit pp = q.size() != 0 && m_ready;
      automatic bit full = q.size() == DEPTH;
      automatic bit ps = ms == 1 && rgb_valid && (!full || pp);
      if (ms == 1 && rgb_valid && full && !pp) movf = 1;
      mdone = 0;
      if (pp) begin
        void'(q.pop_front());
        if (oc == tot - 1) begin
          mdone = 1;
          ms = 0;
          oc = 0;
        end else oc++;
      end
      if (ps) begin
        q.push_back('{cv({r_in, g_in, b_in}), pc % mw, pc / mw});
        pc++;
        if (pc == tot) ms = 2;
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start(int w, int h);
    img_width = 16'(w);
    img_height = 16'(h);
    frame_start = 1;
    cyc(1);
    frame_start = 0;
  endtask
  task automatic push(logic [23:0] p);
    {r_in, g_in, b_in} = p;
    rgb_valid = 1;
    cyc(1);
    rgb_valid = 0;
  endtask
  initial begin
    cyc(3);
    rst = 0;
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_data", 32'(m_data), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    m_ready = 1;
    start(4, 2);
    push(pix(0));
    chk("s1_first_valid", 32'(m_valid), 32'h1);
    chk("s1_first_data", 32'(m_data), 32'(cv(pix(0))));
    chk("s1_first_sof", 32'(m_sof), 32'h1);
    for (int i = 1; i < 8; i++) push(pix(i));
    cyc(3);
    chk("s1_done_count", 32'(dcount), 32'd1);
    m_ready = 0;
    start(8, 4);
    for (int i = 0; i < 17; i++) push(pix(i + 10));
    chk("s2_level_full", 32'(level), 32'd16);
    chk("s2_overflow", 32'(overflow), 32'h1);
    m_ready = 1;
    push(pix(50));
    chk("s2_level_pushpop", 32'(level), 32'd16);
    cyc(20);
    chk("s2_drained", 32'(level), 32'h0);
    m_ready = 0;
    start(2, 1);
    for (int i = 0; i < 3; i++) push(pix(i + 60));
    chk("s3_level", 32'(level), 32'd2);
    chk("s3_overflow", 32'(overflow), 32'h0);
    m_ready = 1;
    cyc(4);
    chk("s3_done_count", 32'(dcount), 32'd2);
    m_ready = 0;
    start(4, 2);
    for (int i = 0; i < 3; i++) push(pix(i + 65));
    {r_in, g_in, b_in} = pix(69);
    frame_start = 1;
    rgb_valid = 1;
    m_ready = 1;
    cyc(1);
    {frame_start, rgb_valid, m_ready} = '0;
    chk("s4_level", 32'(level), 32'h0);
    chk("s4_valid", 32'(m_valid), 32'h0);
    push(pix(70));
    chk("s4_sof", 32'(m_sof), 32'h1);
    chk("s4_level1", 32'(level), 32'd1);
    m_ready = 1;
    cyc(2);
    m_ready = 0;
    start(4, 2);
    for (int i = 0; i < 5; i++) push(pix(i + 80));
    rst = 1;
    cyc(1);
    rst = 0;
    chk("s5_valid", 32'(m_valid), 32'h0);
    chk("s5_level", 32'(level), 32'h0);
    cyc(5);
    chk("s5_no_done", 32'(dcount), 32'd2);
    start(0, 3);
    push(pix(90));
    push(pix(91));
    chk("s6_zero_dim", 32'(level), 32'h0);
    start(1, 1);
    push(24'hF8FCF8);
`ifdef JPEG_PIXEL_SINK_RGB565_EN
    chk("s6_data", 32'(m_data), 32'h00FFFF);
`else
    chk("s6_data", 32'(m_data), 32'hF8FCF8);
`endif
    m_ready = 1;
    cyc(3);
    chk("s6_done_count", 32'(dcount), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, errs);
    $finish;
  end
endmodule
